cla_adder_pipe: RTL and testbench

Pipelined, parametrised carry-lookahead adder/subtractor with a valid/ready stream interface. It splits a WIDTH-bit operand into BLOCK_SIZE-bit lookahead blocks and spreads them across STAGES register stages, so the adder closes timing at wide widths and still sustains one result per cycle. It sits in the datapath as the drop-in replacement for the combinational CLA when an operation must be registered, stalled by a consumer, or switched between add and subtract.

---
 rtl/cla_adder_pipe.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cla_adder_pipe
// Description : Pipelined carry-lookahead adder/subtractor with a valid/ready
//               stream interface. WIDTH bits are split into BLOCK_SIZE-bit
//               lookahead blocks, spread evenly over STAGES register stages.
//               Optional macro CLA_PIPE_FLAGS_EN adds registered signed
//               overflow (out_ovf) and zero (out_zero) result flags.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_adder_pipe #(
    parameter int WIDTH      = 32,
    parameter int BLOCK_SIZE = 4,
    parameter int STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef CLA_PIPE_FLAGS_EN
    ,
    output logic             out_ovf,
    output logic             out_zero
`endif
);

    localparam int NUM_BLOCKS = WIDTH / BLOCK_SIZE;
    localparam int BPS        = NUM_BLOCKS / STAGES;
    localparam int SW         = BPS * BLOCK_SIZE;
    localparam int LAST       = STAGES - 1;

    // Subtraction is A + ~B + 1; the carry-in is forced high in that mode.
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;
    assign w_b_eff = in_sub ? ~in_b : in_b;
    assign w_c0    = in_sub | in_cin;

    // Per-stage register views shared between neighbouring stages.
    logic [STAGES-1:0] w_st_valid;
    logic [STAGES-1:0] w_st_adv;
    logic [STAGES-1:0] w_st_carry;
    logic [WIDTH-1:0]  w_st_sum [STAGES];
    logic [WIDTH-1:0]  w_st_a   [STAGES];
    logic [WIDTH-1:0]  w_st_b   [STAGES];
`ifdef CLA_PIPE_FLAGS_EN
    logic [STAGES-1:0] w_st_sa;
    logic [STAGES-1:0] w_st_sb;
    logic              w_flag_ovf;
    logic              w_flag_zero;
`endif

    // Backward ready chain: a stage advances when empty or when its successor advances.
    always_comb begin
        logic w_down;
        w_down   = out_ready;
        w_st_adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_st_adv[k] = ~w_st_valid[k] | w_down;
            w_down      = w_st_adv[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SW;

        logic             w_up_valid;
        logic [WIDTH-1:0] w_src_a;
        logic [WIDTH-1:0] w_src_b;
        logic [WIDTH-1:0] w_src_sum;
        logic             w_src_c;
        logic [WIDTH-1:0] w_res_sum;
        logic             w_res_c;
        logic             w_load;
        logic             w_unused_src;

        logic             valid_q, valid_d;
        logic [WIDTH-1:0] sum_q, sum_d;
        logic [WIDTH-1:0] a_q, a_d;
        logic [WIDTH-1:0] b_q, b_d;
        logic             carry_q, carry_d;
`ifdef CLA_PIPE_FLAGS_EN
        logic             w_src_sa, w_src_sb;
        logic             sa_q, sa_d, sb_q, sb_d;
`endif

        if (k == 0) begin : g_src_in
            assign w_up_valid = in_valid;
            assign w_src_a    = in_a;
            assign w_src_b    = w_b_eff;
            assign w_src_sum  = '0;
            assign w_src_c    = w_c0;
`ifdef CLA_PIPE_FLAGS_EN
            assign w_src_sa   = in_a[WIDTH-1];
            assign w_src_sb   = w_b_eff[WIDTH-1];
`endif
        end else begin : g_src_prev
            assign w_up_valid = w_st_valid[k-1];
            assign w_src_a    = w_st_a[k-1];
            assign w_src_b    = w_st_b[k-1];
            assign w_src_sum  = w_st_sum[k-1];
            assign w_src_c    = w_st_carry[k-1];
`ifdef CLA_PIPE_FLAGS_EN
            assign w_src_sa   = w_st_sa[k-1];
            assign w_src_sb   = w_st_sb[k-1];
`endif
        end

        // Bits below this stage's slice were consumed upstream; only the slice and above matter here.
        assign w_unused_src = ^{w_src_a, w_src_b};

        // Two-level lookahead over this stage's blocks: bit-level CLA inside each block,
        // group P/G lookahead across blocks, seeded by the incoming inter-stage carry.
        always_comb begin
            logic [SW-1:0]  bit_g;
            logic [SW-1:0]  bit_p;
            logic [BPS-1:0] grp_g;
            logic [BPS-1:0] grp_p;
            logic [BPS:0]   blk_c;
            logic           term;
            logic           ci;
            bit_g     = w_src_a[LO +: SW] & w_src_b[LO +: SW];
            bit_p     = w_src_a[LO +: SW] ^ w_src_b[LO +: SW];
            grp_g     = '0;
            grp_p     = '0;
            blk_c     = '0;
            term      = 1'b0;
            ci        = 1'b0;
            w_res_sum = w_src_sum;
            for (int j = 0; j < BPS; j++) begin
                grp_p[j] = 1'b1;
                for (int i = 0; i < BLOCK_SIZE; i++) begin
                    grp_p[j] = grp_p[j] & bit_p[j*BLOCK_SIZE + i];
                    term     = bit_g[j*BLOCK_SIZE + i];
                    for (int n = i + 1; n < BLOCK_SIZE; n++) begin
                        term = term & bit_p[j*BLOCK_SIZE + n];
                    end
                    grp_g[j] = grp_g[j] | term;
                end
            end
            blk_c[0] = w_src_c;
            for (int j = 1; j <= BPS; j++) begin
                ci = w_src_c;
                for (int m = 0; m < j; m++) begin
                    ci = ci & grp_p[m];
                end
                for (int m = 0; m < j; m++) begin
                    term = grp_g[m];
                    for (int n = m + 1; n < j; n++) begin
                        term = term & grp_p[n];
                    end
                    ci = ci | term;
                end
                blk_c[j] = ci;
            end
            for (int j = 0; j < BPS; j++) begin
                for (int i = 0; i < BLOCK_SIZE; i++) begin
                    ci = blk_c[j];
                    for (int n = 0; n < i; n++) begin
                        ci = ci & bit_p[j*BLOCK_SIZE + n];
                    end
                    for (int m = 0; m < i; m++) begin
                        term = bit_g[j*BLOCK_SIZE + m];
                        for (int n = m + 1; n < i; n++) begin
                            term = term & bit_p[j*BLOCK_SIZE + n];
                        end
                        ci = ci | term;
                    end
                    w_res_sum[LO + j*BLOCK_SIZE + i] = bit_p[j*BLOCK_SIZE + i] ^ ci;
                end
            end
            w_res_c = blk_c[BPS];
        end

        assign w_load = w_up_valid & w_st_adv[k];

        // Stage register next state: load on accept, drain when advancing empty-handed, else hold.
        always_comb begin
            valid_d = valid_q;
            sum_d   = sum_q;
            a_d     = a_q;
            b_d     = b_q;
            carry_d = carry_q;
            if (w_load) begin
                valid_d = 1'b1;
                sum_d   = w_res_sum;
                a_d     = w_src_a;
                b_d     = w_src_b;
                carry_d = w_res_c;
            end else if (w_st_adv[k]) begin
                valid_d = 1'b0;
            end
        end

        // Stage register with asynchronous clear discarding any in-flight operation.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
                a_q     <= '0;
                b_q     <= '0;
                carry_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
                sum_q   <= sum_d;
                a_q     <= a_d;
                b_q     <= b_d;
                carry_q <= carry_d;
            end
        end

        assign w_st_valid[k] = valid_q;
        assign w_st_sum[k]   = sum_q;
        assign w_st_a[k]     = a_q;
        assign w_st_b[k]     = b_q;
        assign w_st_carry[k] = carry_q;

`ifdef CLA_PIPE_FLAGS_EN
        // Operand sign bits follow the operation so the last stage can judge overflow.
        always_comb begin
            sa_d = w_load ? w_src_sa : sa_q;
            sb_d = w_load ? w_src_sb : sb_q;
        end

        // Sign-bit registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sa_q <= 1'b0;
                sb_q <= 1'b0;
            end else begin
                sa_q <= sa_d;
                sb_q <= sb_d;
            end
        end

        assign w_st_sa[k] = sa_q;
        assign w_st_sb[k] = sb_q;

        if (k == LAST) begin : g_flags
            logic ovf_q, ovf_d;
            logic zero_q, zero_d;

            // Flags are computed from the completed sum and captured alongside it.
            always_comb begin
                ovf_d  = ovf_q;
                zero_d = zero_q;
                if (w_load) begin
                    ovf_d  = (w_src_sa == w_src_sb) & (w_res_sum[WIDTH-1] != w_src_sa);
                    zero_d = (w_res_sum == '0);
                end
            end

            // Flag registers, cleared with the rest of the pipeline.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else begin
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end

            assign w_flag_ovf  = ovf_q;
            assign w_flag_zero = zero_q;
        end
`endif
    end

    // The last stage's operand copies have no consumer.
    logic w_unused_tail;
    assign w_unused_tail = ^{w_st_a[LAST], w_st_b[LAST]};
`ifdef CLA_PIPE_FLAGS_EN
    logic w_unused_tail_sign;
    assign w_unused_tail_sign = w_st_sa[LAST] ^ w_st_sb[LAST];
    assign out_ovf  = w_flag_ovf;
    assign out_zero = w_flag_zero;
`endif

    assign in_ready  = w_st_adv[0];
    assign out_valid = w_st_valid[LAST];
    assign out_sum   = w_st_sum[LAST];
    assign out_cout  = w_st_carry[LAST];

endmodule
`default_nettype wire

// File: tb/tb_cla_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_adder_pipe
// Description : Self-checking bench for cla_adder_pipe (32-bit, 4-bit blocks,
//               2 stages) using directed vectors and a queue-based
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_adder_pipe;

    localparam int W  = 32;
    localparam int BS = 4;
    localparam int ST = 2;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic         in_cin    = 1'b0;
    logic         in_sub    = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef CLA_PIPE_FLAGS_EN
    logic         out_ovf;
    logic         out_zero;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    res_t exp_q[$];

    always #5 clk = ~clk;

    cla_adder_pipe #(
        .WIDTH      (W),
        .BLOCK_SIZE (BS),
        .STAGES     (ST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef CLA_PIPE_FLAGS_EN
        ,
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
`endif
    );

    // Reference: plain unsigned/signed integer arithmetic.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        res_t    r;
        logic [W:0] wide;
        longint  sa, sb, s, maxv, minv;
        if (sub) begin
            r.sum  = a - b;
            r.cout = (a >= b);
        end else begin
            wide   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            r.sum  = wide[W-1:0];
            r.cout = wide[W];
        end
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        s    = sub ? (sa - sb) : (sa + sb + longint'(cin));
        maxv = (longint'(1) <<< (W - 1)) - 1;
        minv = -(longint'(1) <<< (W - 1));
        r.ovf  = (s > maxv) || (s < minv);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid  = 1'($urandom);
            in_a      = $urandom;
            in_b      = $urandom;
            in_cin    = 1'($urandom);
            in_sub    = 1'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
            end
            total++;
            if (out_sum !== '0 || out_cout !== 1'b0) begin
                bad++; $display("FAIL reset_data: got sum=%h cout=%b want 0/0", out_sum, out_cout);
            end
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
            end
`ifdef CLA_PIPE_FLAGS_EN
            total++;
            if (out_ovf !== 1'b0 || out_zero !== 1'b0) begin
                bad++; $display("FAIL reset_flags: got ovf=%b zero=%b want 0/0", out_ovf, out_zero);
            end
`endif
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL reset_release_valid: got %b want 0", out_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_carry();
        logic [W-1:0] ta [2];
        logic [W-1:0] tb [2];
        logic [W-1:0] es [2];
        logic         tc [2];
        logic         ec [2];
        int           lat;
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h0000_0001; tc[0] = 1'b0; es[0] = 32'h0000_0000; ec[0] = 1'b1;
        ta[1] = 32'h0000_FFFF; tb[1] = 32'h0000_0000; tc[1] = 1'b1; es[1] = 32'h0001_0000; ec[1] = 1'b0;
        for (int v = 0; v < 2; v++) begin
            in_a = ta[v]; in_b = tb[v]; in_cin = tc[v]; in_sub = 1'b0;
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL carry_in_ready: got %b want 1", in_ready);
            end
            @(posedge clk); #1;
            in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
            lat = 0;
            @(negedge clk);
            while (out_valid !== 1'b1 && lat < 20) begin
                @(posedge clk); #1; lat++;
                @(negedge clk);
            end
            total++;
            if (lat != ST - 1) begin
                bad++; $display("FAIL carry_latency: got %0d extra edges want %0d", lat, ST - 1);
            end
            total++;
            if (out_sum !== es[v] || out_cout !== ec[v]) begin
                bad++; $display("FAIL carry_result%0d: got %h/%b want %h/%b", v, out_sum, out_cout, es[v], ec[v]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        logic [W-1:0] es [3];
        logic         tc [3];
        logic         ec [3];
        int           wt;
        ta[0] = 32'd7; tb[0] = 32'd5; tc[0] = 1'b0; es[0] = 32'h0000_0002; ec[0] = 1'b1;
        ta[1] = 32'd5; tb[1] = 32'd7; tc[1] = 1'b0; es[1] = 32'hFFFF_FFFE; ec[1] = 1'b0;
        ta[2] = 32'd7; tb[2] = 32'd5; tc[2] = 1'b1; es[2] = 32'h0000_0002; ec[2] = 1'b1;
        for (int v = 0; v < 3; v++) begin
            in_a = ta[v]; in_b = tb[v]; in_cin = tc[v]; in_sub = 1'b1;
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            wt = 0;
            @(negedge clk);
            while (out_valid !== 1'b1 && wt < 20) begin
                @(posedge clk); #1; wt++;
                @(negedge clk);
            end
            total++;
            if (out_sum !== es[v] || out_cout !== ec[v]) begin
                bad++; $display("FAIL sub_result%0d: got %h/%b want %h/%b", v, out_sum, out_cout, es[v], ec[v]);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef CLA_PIPE_FLAGS_EN
    task automatic test_flags();
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        logic [W-1:0] es [3];
        logic         tsub [3];
        logic         ec [3];
        logic         eo [3];
        logic         ez [3];
        int           wt;
        ta[0] = 32'h7FFF_FFFF; tb[0] = 32'd1; tsub[0] = 1'b0; es[0] = 32'h8000_0000; ec[0] = 1'b0; eo[0] = 1'b1; ez[0] = 1'b0;
        ta[1] = 32'd5;         tb[1] = 32'd5; tsub[1] = 1'b1; es[1] = 32'h0000_0000; ec[1] = 1'b1; eo[1] = 1'b0; ez[1] = 1'b1;
        ta[2] = 32'h8000_0000; tb[2] = 32'd1; tsub[2] = 1'b1; es[2] = 32'h7FFF_FFFF; ec[2] = 1'b1; eo[2] = 1'b1; ez[2] = 1'b0;
        for (int v = 0; v < 3; v++) begin
            in_a = ta[v]; in_b = tb[v]; in_cin = 1'b0; in_sub = tsub[v];
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            wt = 0;
            @(negedge clk);
            while (out_valid !== 1'b1 && wt < 20) begin
                @(posedge clk); #1; wt++;
                @(negedge clk);
            end
            total++;
            if (out_sum !== es[v] || out_cout !== ec[v] || out_ovf !== eo[v] || out_zero !== ez[v]) begin
                bad++;
                $display("FAIL flags%0d: got %h/c%b/o%b/z%b want %h/c%b/o%b/z%b", v,
                         out_sum, out_cout, out_ovf, out_zero, es[v], ec[v], eo[v], ez[v]);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    // mode 0: continuous stream, 1: consumer stalls cycles 2..5, 2: random valid/ready.
    task automatic test_stream(input string name, input int nops, input int mode);
        int   issued;
        int   got;
        int   cyc;
        bit   saw_stall;
        logic exp_rdy;
        res_t e;
        issued = 0; got = 0; cyc = 0; saw_stall = 1'b0;
        exp_q.delete();
        while ((issued < nops || exp_q.size() > 0) && cyc < 600) begin
            if (issued < nops) begin
                in_valid = (mode == 2) ? 1'($urandom) : 1'b1;
                in_a     = $urandom;
                in_b     = ($urandom_range(0, 7) == 0) ? in_a : $urandom;
                in_cin   = 1'($urandom);
                in_sub   = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !(cyc >= 2 && cyc <= 5);
                default: out_ready = 1'($urandom);
            endcase
            @(negedge clk);
            exp_rdy = !(exp_q.size() == ST && !out_ready);
            total++;
            if (in_ready !== exp_rdy) begin
                bad++; $display("FAIL %s_in_ready: cycle %0d got %b want %b", name, cyc, in_ready, exp_rdy);
            end
            if (in_ready === 1'b0) saw_stall = 1'b1;
            if (out_valid === 1'b1 && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL %s_spurious: got out_valid=1 want no result pending", name);
                end else begin
                    e = exp_q.pop_front();
                    got++;
`ifdef CLA_PIPE_FLAGS_EN
                    if ({out_sum, out_cout, out_ovf, out_zero} !== {e.sum, e.cout, e.ovf, e.zero}) begin
                        bad++;
                        $display("FAIL %s_result: got %h/c%b/o%b/z%b want %h/c%b/o%b/z%b", name,
                                 out_sum, out_cout, out_ovf, out_zero, e.sum, e.cout, e.ovf, e.zero);
                    end
`else
                    if ({out_sum, out_cout} !== {e.sum, e.cout}) begin
                        bad++;
                        $display("FAIL %s_result: got %h/c%b want %h/c%b", name, out_sum, out_cout, e.sum, e.cout);
                    end
`endif
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
                issued++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != nops) begin
            bad++; $display("FAIL %s_count: got %0d results want %0d", name, got, nops);
        end
        if (mode == 1) begin
            total++;
            if (!saw_stall) begin
                bad++; $display("FAIL %s_stall: got in_ready never low want low while full", name);
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL %s_extra: got out_valid=%b want 0 after drain", name, out_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        test_stream("b2b", 20, 0);
    endtask

    task automatic test_backpressure();
        test_stream("bp", 6, 1);
    endtask

    task automatic test_random();
        test_stream("rand", 60, 2);
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sub    = 1'b0;
        in_cin    = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_a = $urandom;
            in_b = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL midrst_pre: got out_valid=%b want 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_clear: got out_valid=%b want 0", out_valid);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_ready: got in_ready=%b want 1", in_ready);
        end
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL midrst_discard: got out_valid=%b want 0", out_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_sub();
`ifdef CLA_PIPE_FLAGS_EN
        test_flags();
`endif
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit reached want test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
